// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   XLEN_DEFAULT : default datapath width (32 or 64 are the legal widths)
//   op_e         : operation codes carried on the Op port (13-15 are illegal)
//   state_e      : control FSM states of muldiv_unit
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 64;

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_MULW   = 4'd8,
        OP_DIVW   = 4'd9,
        OP_DIVUW  = 4'd10,
        OP_REMW   = 4'd11,
        OP_REMUW  = 4'd12
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_predecode.sv
// muldiv_predecode: combinational operand decode for muldiv_unit.
//   op_i        : operation code
//   src_a_i/b_i : raw operands
//   is_mul_o    : multiply family (else divide/remainder)
//   is_hi_o     : multiply returns the upper half of the product
//   is_rem_o    : divide family returns the remainder
//   is_w_o      : 32-bit word operation
//   a_neg_o/b_neg_o : operand is treated as signed and is negative
//   a_mag_o/b_mag_o : operand magnitudes after word extension
//   a_res_o     : dividend as it appears in a result (word ops sign-extended)
//   div_zero_o, overflow_o, illegal_o : early-completion conditions
module muldiv_predecode
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    output logic            is_mul_o,
    output logic            is_hi_o,
    output logic            is_rem_o,
    output logic            is_w_o,
    output logic            a_neg_o,
    output logic            b_neg_o,
    output logic [XLEN-1:0] a_mag_o,
    output logic [XLEN-1:0] b_mag_o,
    output logic [XLEN-1:0] a_res_o,
    output logic            div_zero_o,
    output logic            overflow_o,
    output logic            illegal_o
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
        ext32 = {XLEN{sgn & v[31]}};
        ext32[31:0] = v;
    endfunction

    logic            a_signed;
    logic            b_signed;
    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic            ovf_pattern;

    always_comb begin
        is_mul_o  = 1'b0;
        is_hi_o   = 1'b0;
        is_rem_o  = 1'b0;
        is_w_o    = 1'b0;
        illegal_o = 1'b0;
        a_signed  = 1'b0;
        b_signed  = 1'b0;
        case (op_i)
            OP_MUL:    is_mul_o = 1'b1;
            OP_MULH:   begin is_mul_o = 1'b1; is_hi_o = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
            OP_MULHSU: begin is_mul_o = 1'b1; is_hi_o = 1'b1; a_signed = 1'b1; end
            OP_MULHU:  begin is_mul_o = 1'b1; is_hi_o = 1'b1; end
            OP_DIV:    begin a_signed = 1'b1; b_signed = 1'b1; end
            OP_DIVU:   ;
            OP_REM:    begin is_rem_o = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
            OP_REMU:   is_rem_o = 1'b1;
            // Word ops only exist on a 64-bit datapath.
            OP_MULW:   if (XLEN == 32) illegal_o = 1'b1;
                       else begin is_w_o = 1'b1; is_mul_o = 1'b1; end
            OP_DIVW:   if (XLEN == 32) illegal_o = 1'b1;
                       else begin is_w_o = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
            OP_DIVUW:  if (XLEN == 32) illegal_o = 1'b1;
                       else is_w_o = 1'b1;
            OP_REMW:   if (XLEN == 32) illegal_o = 1'b1;
                       else begin is_w_o = 1'b1; is_rem_o = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
            OP_REMUW:  if (XLEN == 32) illegal_o = 1'b1;
                       else begin is_w_o = 1'b1; is_rem_o = 1'b1; end
            default:   illegal_o = 1'b1;
        endcase

        a_ext = is_w_o ? ext32(src_a_i[31:0], a_signed) : src_a_i;
        b_ext = is_w_o ? ext32(src_b_i[31:0], b_signed) : src_b_i;

        a_neg_o = a_signed & a_ext[XLEN-1];
        b_neg_o = b_signed & b_ext[XLEN-1];
        a_mag_o = a_neg_o ? -a_ext : a_ext;
        b_mag_o = b_neg_o ? -b_ext : b_ext;
        a_res_o = is_w_o ? ext32(src_a_i[31:0], 1'b1) : src_a_i;

        // Most-negative / -1 is checked on the raw word for W ops, since the
        // sign-extended word is not the XLEN-wide most-negative value.
        ovf_pattern = is_w_o ? (src_a_i[31:0] == 32'h8000_0000 && src_b_i[31:0] == 32'hFFFF_FFFF)
                             : (src_a_i == MIN_NEG && src_b_i == {XLEN{1'b1}});

        div_zero_o = ~is_mul_o & ~illegal_o & (b_ext == '0);
        overflow_o = ~is_mul_o & ~illegal_o & a_signed & b_signed & ovf_pattern;
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: radix-2 iterative integer multiply/divide unit.
//   clk, reset   : clock and synchronous active-high reset
//   Start        : request; Op/SrcA/SrcB are captured on the accepting edge
//   Flush        : abort any in-flight operation
//   Op           : operation code (muldiv_pkg::op_e)
//   SrcA, SrcB   : operands
//   Busy         : high while an operation iterates (CALC) or is corrected (FIX)
//   Done         : one-cycle pulse, Result is valid in that cycle
//   Result       : last result, kept until a later operation completes
//   dbg_state_o  : current FSM state for observation
//
// Handshake: an edge with Start=1, Busy=0, Flush=0 and reset=0 accepts the
// request (this includes the Done cycle). Start at any other edge is dropped.
// Done rises N+2 cycles after the accept (N = 32 for word ops, XLEN
// otherwise), or one cycle after it for divide-by-zero, signed overflow and
// illegal codes, which skip the iteration entirely.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Start,
    input  logic            Flush,
    input  logic [3:0]      Op,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result,
    output logic [1:0]      dbg_state_o
);

    localparam int CW      = $clog2(XLEN) + 1;
    localparam int W_SHIFT = XLEN - 32;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        sext32 = {XLEN{v[31]}};
        sext32[31:0] = v;
    endfunction

    logic            pd_is_mul, pd_is_hi, pd_is_rem, pd_is_w;
    logic            pd_a_neg, pd_b_neg;
    logic [XLEN-1:0] pd_a_mag, pd_b_mag, pd_a_res;
    logic            pd_div_zero, pd_overflow, pd_illegal;

    muldiv_predecode #(.XLEN(XLEN)) u_predecode (
        .op_i       (Op),
        .src_a_i    (SrcA),
        .src_b_i    (SrcB),
        .is_mul_o   (pd_is_mul),
        .is_hi_o    (pd_is_hi),
        .is_rem_o   (pd_is_rem),
        .is_w_o     (pd_is_w),
        .a_neg_o    (pd_a_neg),
        .b_neg_o    (pd_b_neg),
        .a_mag_o    (pd_a_mag),
        .b_mag_o    (pd_b_mag),
        .a_res_o    (pd_a_res),
        .div_zero_o (pd_div_zero),
        .overflow_o (pd_overflow),
        .illegal_o  (pd_illegal)
    );

    state_e            state_q;
    logic              busy_q, done_q;
    logic [XLEN-1:0]   result_q;
    logic [CW-1:0]     cnt_q;
    // Multiply: {partial product high, multiplier / product low}.
    // Divide:   {partial remainder, dividend shifting out / quotient in}.
    logic [2*XLEN-1:0] acc_q;
    // Multiplicand for multiply, divisor magnitude for divide.
    logic [XLEN-1:0]   opnd_q;
    logic              is_mul_q, is_hi_q, is_rem_q, is_w_q, neg_q;

    logic [2*XLEN-1:0] load_acc_d;
    logic [XLEN-1:0]   load_opnd_d;
    logic [CW-1:0]     load_cnt_d;
    logic              load_neg_d;
    logic [XLEN-1:0]   bypass_result_d;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_sh;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] step_acc_d;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_mag;
    logic [XLEN-1:0]   div_fix;
    logic [XLEN-1:0]   fix_result_d;

    always_comb begin
        // Word divides park the 32-bit dividend at the top of the low half so
        // that 32 shifts bring every dividend bit into the remainder.
        load_acc_d  = '0;
        load_acc_d[XLEN-1:0] = pd_is_mul ? pd_b_mag
                             : (pd_is_w ? (pd_a_mag << W_SHIFT) : pd_a_mag);
        load_opnd_d = pd_is_mul ? pd_a_mag : pd_b_mag;
        load_cnt_d  = pd_is_w ? CW'(31) : CW'(XLEN - 1);
        load_neg_d  = pd_is_rem ? pd_a_neg : (pd_a_neg ^ pd_b_neg);

        bypass_result_d = '0;
        if (pd_illegal)       bypass_result_d = '0;
        else if (pd_div_zero) bypass_result_d = pd_is_rem ? pd_a_res : {XLEN{1'b1}};
        else if (pd_overflow) bypass_result_d = pd_is_rem ? '0 : pd_a_res;

        // Shift-add step: add the multiplicand when the multiplier LSB is set,
        // then shift the whole accumulator right keeping the carry.
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

        // Restoring step: shift in the next dividend bit, subtract if it fits.
        // The shifted remainder is below twice the divisor, so the top bit of
        // the difference is a valid borrow.
        div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff = div_sh - {1'b0, opnd_q};
        div_ge   = ~div_diff[XLEN];

        step_acc_d = is_mul_q ? {mul_sum, acc_q[XLEN-1:1]}
                              : {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]),
                                 acc_q[XLEN-2:0], div_ge};

        prod_fix = neg_q ? -acc_q : acc_q;
        div_mag  = is_rem_q ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        div_fix  = neg_q ? -div_mag : div_mag;

        // A 32-step word multiply leaves its product shifted up by XLEN-32.
        if (is_mul_q) begin
            if (is_w_q)       fix_result_d = sext32(acc_q[XLEN-1:XLEN-32]);
            else if (is_hi_q) fix_result_d = prod_fix[2*XLEN-1:XLEN];
            else              fix_result_d = prod_fix[XLEN-1:0];
        end else begin
            fix_result_d = is_w_q ? sext32(div_fix[31:0]) : div_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_mul_q <= 1'b0;
            is_hi_q  <= 1'b0;
            is_rem_q <= 1'b0;
            is_w_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else if (Flush) begin
            // Abort: Result keeps its last completed value.
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    if (Start) begin
                        if (pd_div_zero || pd_overflow || pd_illegal) begin
                            result_q <= bypass_result_d;
                            state_q  <= ST_DONE;
                            done_q   <= 1'b1;
                        end else begin
                            state_q  <= ST_CALC;
                            busy_q   <= 1'b1;
                            acc_q    <= load_acc_d;
                            opnd_q   <= load_opnd_d;
                            cnt_q    <= load_cnt_d;
                            is_mul_q <= pd_is_mul;
                            is_hi_q  <= pd_is_hi;
                            is_rem_q <= pd_is_rem;
                            is_w_q   <= pd_is_w;
                            neg_q    <= load_neg_d;
                        end
                    end
                end
                ST_CALC: begin
                    acc_q <= step_acc_d;
                    if (cnt_q == '0) state_q <= ST_FIX;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                ST_FIX: begin
                    result_q <= fix_result_d;
                    state_q  <= ST_DONE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Result      = result_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit at XLEN=64.
// The driver pushes the expected result and completion cycle for each issued
// operation; an independent monitor pops them on every Done pulse.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 64;
    localparam logic [W-1:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [W-1:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset, Start, Flush;
    logic [3:0]   Op;
    logic [W-1:0] SrcA, SrcB;
    logic         Busy, Done;
    logic [W-1:0] Result;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_unit #(.XLEN(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .Start       (Start),
        .Flush       (Flush),
        .Op          (Op),
        .SrcA        (SrcA),
        .SrcB        (SrcB),
        .Busy        (Busy),
        .Done        (Done),
        .Result      (Result),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int unsigned  cyc_q[$];
    int           n_vec = 0;
    int           n_mis = 0;
    logic [W-1:0] last_res = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_num(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void ref_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] res, output int lat);
        logic [127:0]       prod;
        logic signed [63:0] sa, sb;
        logic signed [31:0] wa, wb;
        logic [31:0]        ua, ub, w;
        sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
        res = '0; lat = 66; w = '0; prod = '0;
        case (op)
            4'd0: res = a * b;
            4'd1: begin prod = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); res = prod[127:64]; end
            4'd2: begin prod = $signed({{64{a[63]}}, a}) * $signed({64'b0, b}); res = prod[127:64]; end
            4'd3: begin prod = {64'b0, a} * {64'b0, b}; res = prod[127:64]; end
            4'd4: if (b == 0) begin res = ONES; lat = 1; end
                  else if (a == MIN64 && b == ONES) begin res = a; lat = 1; end
                  else res = sa / sb;
            4'd5: if (b == 0) begin res = ONES; lat = 1; end
                  else res = a / b;
            4'd6: if (b == 0) begin res = a; lat = 1; end
                  else if (a == MIN64 && b == ONES) begin res = '0; lat = 1; end
                  else res = sa % sb;
            4'd7: if (b == 0) begin res = a; lat = 1; end
                  else res = a % b;
            4'd8: begin w = ua * ub; lat = 34; end
            4'd9: begin
                lat = 34;
                if (ub == 0) begin w = 32'hFFFF_FFFF; lat = 1; end
                else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) begin w = ua; lat = 1; end
                else w = wa / wb;
            end
            4'd10: begin
                lat = 34;
                if (ub == 0) begin w = 32'hFFFF_FFFF; lat = 1; end
                else w = ua / ub;
            end
            4'd11: begin
                lat = 34;
                if (ub == 0) begin w = ua; lat = 1; end
                else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) begin w = '0; lat = 1; end
                else w = wa % wb;
            end
            4'd12: begin
                lat = 34;
                if (ub == 0) begin w = ua; lat = 1; end
                else w = ua % ub;
            end
            default: begin res = '0; lat = 1; end
        endcase
        if (op >= 4'd8 && op <= 4'd12) res = {{32{w[31]}}, w};
    endfunction

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [W-1:0] e;
        int unsigned  c;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && Done) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_mis++;
                    $display("FAIL unexpected_done: Done at cycle %0d with nothing pending, Result 0x%h", cyc, Result);
                end else begin
                    e = exp_q.pop_front();
                    c = cyc_q.pop_front();
                    check("result", Result, e);
                    check_num("done_cycle", cyc, c);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic push_exp(input logic [W-1:0] res, input int lat);
        exp_q.push_back(res);
        cyc_q.push_back(cyc + lat);
        last_res = res;
    endtask

    task automatic issue_raw(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        Start = 1'b1; Op = op; SrcA = a; SrcB = b;
        tick();
        Start = 1'b0;
    endtask

    task automatic run_ref(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        int           l;
        ref_model(op, a, b, r, l);
        push_exp(r, l);
        issue_raw(op, a, b);
    endtask

    task automatic run_const(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] r, input int l);
        push_exp(r, l);
        issue_raw(op, a, b);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (Done) seen = 1'b1;
            else tick();
        end
        if (!seen) begin
            n_vec++;
            n_mis++;
            $display("FAIL done_timeout: no Done within 200 cycles, %0d results pending", exp_q.size());
            exp_q.delete();
            cyc_q.delete();
        end
    endtask

    task automatic gen(output logic [W-1:0] v);
        case ($urandom_range(0, 11))
            0:       v = $urandom_range(0, 20);
            1:       v = '0;
            2:       v = MIN64;
            3:       v = ONES;
            4:       v = {$urandom, 32'h8000_0000};
            5:       v = {$urandom, 32'hFFFF_FFFF};
            6:       v = -64'($urandom_range(1, 50));
            7:       v = {32'h0, $urandom};
            default: v = {$urandom, $urandom};
        endcase
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: time limit reached with %0d results pending", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        logic [W-1:0] a, b;
        logic [3:0]   op;
        reset = 1'b1; Start = 1'b0; Flush = 1'b0; Op = '0; SrcA = '0; SrcB = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", Busy, 0);
        check("reset_done", Done, 0);
        check("reset_result", Result, 0);
        check("reset_state", dbg_state, 0);
        reset = 1'b0;
        tick();

        // Full-width multiply with Busy traced over the whole operation.
        run_const(4'd0, ONES, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        for (int k = 1; k <= 66; k++) begin
            check($sformatf("busy_c%0d", k), Busy, (k <= 65) ? 1 : 0);
            if (k < 66) tick();
        end
        wait_done();

        // Back-to-back upper-half multiplies.
        run_const(4'd3, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        wait_done();
        run_const(4'd1, ONES, ONES, 64'h0, 66);
        wait_done();
        idle(2);

        // Early completions: divide by zero and signed overflow.
        run_const(4'd4, 64'd7, 64'd0, ONES, 1);
        wait_done();
        run_const(4'd6, 64'd7, 64'd0, 64'd7, 1);
        wait_done();
        run_const(4'd4, MIN64, ONES, MIN64, 1);
        wait_done();
        run_const(4'd6, MIN64, ONES, 64'd0, 1);
        wait_done();
        run_const(4'd13, 64'd5, 64'd9, 64'd0, 1);
        wait_done();
        idle(1);

        // Word divides.
        run_const(4'd9, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);
        wait_done();
        run_const(4'd11, 64'h0000_0000_FFFF_FFF9, 64'd2, ONES, 34);
        wait_done();
        idle(1);

        // Start while busy must be ignored (it would otherwise complete early).
        run_const(4'd0, 64'd12345, 64'd678, 64'd8369910, 66);
        idle(5);
        Start = 1'b1; Op = 4'd4; SrcA = 64'd7; SrcB = 64'd0;
        tick();
        Start = 1'b0;
        wait_done();
        idle(1);

        // Flush in cycle 10 of a DIVU.
        issue_raw(4'd5, 64'd1000, 64'd7);
        idle(9);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        check("flush_busy", Busy, 0);
        check("flush_result", Result, last_res);
        idle(70);
        run_const(4'd0, 64'd5, 64'd6, 64'd30, 66);
        wait_done();
        run_const(4'd0, 64'd7, 64'd8, 64'd56, 66);
        wait_done();
        idle(1);

        // Flush and Start together: nothing is accepted.
        Start = 1'b1; Flush = 1'b1; Op = 4'd3; SrcA = 64'd9; SrcB = 64'd9;
        tick();
        Start = 1'b0; Flush = 1'b0;
        check("flush_start_busy", Busy, 0);
        idle(70);

        // Reset in the middle of CALC discards the operation.
        issue_raw(4'd4, 64'd1000, 64'd3);
        idle(5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_busy", Busy, 0);
        check("midreset_done", Done, 0);
        check("midreset_result", Result, 0);
        last_res = '0;
        idle(70);

        // Randomized operations, with random gaps including back-to-back.
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            gen(a);
            gen(b);
            run_ref(op, a, b);
            wait_done();
            idle($urandom_range(0, 2));
        end

        idle(5);
        check_num("pending_at_end", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
